addsub_stream_arbiter: RTL

- Shares one `adder32bit` recursive-doubling adder between two requesters.
- Each requester submits multi-word add/subtract transactions as a stream of 32-bit words, least-significant word first.
- The block grants one requester at a time with round-robin arbitration and chains carry between words.
- It returns a registered result stream tagged with the requester ID. It sits between the multiplier/accumulator datapath clients and the shared adder.

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/adder32bit.sv | 38 +++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/addsub_stream_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants, FSM state type and small helpers
// for the shared add/subtract stream arbiter.
package addsub_pkg;

   localparam int WORD_W = 32;
   localparam int NREQ   = 2;
   localparam int LVLS   = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Signed overflow: operands share a sign that the sum does not.
   function automatic logic signed_ovf(
      input logic a_msb,
      input logic b_msb,
      input logic s_msb
   );
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder32bit.sv
// Recursive-doubling (Kogge-Stone) 32-bit adder with carry in/out.
// Five prefix levels of generate/propagate, all combinational.
module adder32bit
   import addsub_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   logic [WORD_W:0] carry;

   genvar l;
   for (l = 0; l <= LVLS; l++) begin : lvl
      logic [WORD_W-1:0] gv;
      logic [WORD_W-1:0] pv;
      if (l == 0) begin : g_base
         assign gv = a & b;
         assign pv = a ^ b;
      end else begin : g_step
         localparam int D = 1 << (l - 1);
         // Low bits already span down to bit 0; keep their group propagate.
         localparam logic [WORD_W-1:0] LOW =
            {WORD_W{1'b1}} >> (WORD_W - D);
         assign gv = lvl[l-1].gv |
                     (lvl[l-1].pv & (lvl[l-1].gv << D));
         assign pv = lvl[l-1].pv &
                     ((lvl[l-1].pv << D) | LOW);
      end
   end

   assign carry = {lvl[LVLS].gv | (lvl[LVLS].pv & {WORD_W{cin}}), cin};
   assign sum   = lvl[0].pv ^ carry[WORD_W-1:0];
   assign cout  = carry[WORD_W];

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant decision: a lone request wins,
// contention is resolved by the pointer.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       gnt_id,
   output logic       any
);

   always_comb begin
      gnt_id = 1'b0;
      unique case (1'b1)
         (req == 2'b11): gnt_id = ptr;
         (req == 2'b10): gnt_id = 1'b1;
         default:        gnt_id = 1'b0;
      endcase
   end

   assign any = |req;

endmodule

// File: rtl/addsub_stream_arbiter.sv
// Shares one adder32bit between two multi-word add/sub requesters,
// chaining carry across words and returning a registered tagged stream.
module addsub_stream_arbiter
   import addsub_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*WORD_W-1:0] req_a,
   input  logic [NREQ*WORD_W-1:0] req_b,
   input  logic [NREQ-1:0]        req_sub,
   input  logic [NREQ-1:0]        req_last,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WORD_W-1:0]      res_sum,
   output logic                   res_id,
   output logic                   res_last,
   output logic                   res_cout,
   output logic                   res_ovf
);

   state_t st_q, st_d;
   logic   gnt_q, gnt_d;
   logic   rr_ptr_q;
   logic   carry_q;
   logic   sub_q;
   logic   first_q;

   logic   arb_gnt;
   logic   arb_any;
   logic   out_free;
   logic   xfer;

   logic [WORD_W-1:0] a_sel;
   logic [WORD_W-1:0] b_sel;
   logic [WORD_W-1:0] b_eff;
   logic [WORD_W-1:0] add_sum;
   logic              add_cout;
   logic              sub_sel;
   logic              sub_eff;
   logic              last_sel;
   logic              valid_sel;
   logic              cin;

   rr_arbiter2 u_arb (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .gnt_id (arb_gnt),
      .any    (arb_any)
   );

   assign a_sel     = gnt_q ? req_a[2*WORD_W-1:WORD_W]
                            : req_a[WORD_W-1:0];
   assign b_sel     = gnt_q ? req_b[2*WORD_W-1:WORD_W]
                            : req_b[WORD_W-1:0];
   assign sub_sel   = gnt_q ? req_sub[1]   : req_sub[0];
   assign last_sel  = gnt_q ? req_last[1]  : req_last[0];
   assign valid_sel = gnt_q ? req_valid[1] : req_valid[0];

   // Mode and carry-in come from the request only on the first word.
   assign sub_eff = first_q ? sub_sel : sub_q;
   assign cin     = first_q ? sub_sel : carry_q;
   assign b_eff   = sub_eff ? ~b_sel : b_sel;

   adder32bit u_add (
      .a    (a_sel),
      .b    (b_eff),
      .cin  (cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign out_free = !res_valid || res_ready;

   always_comb begin
      st_d      = st_q;
      gnt_d     = gnt_q;
      req_ready = '0;
      xfer      = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (arb_any) begin
               gnt_d = arb_gnt;
               st_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            req_ready[gnt_q] = out_free;
            xfer = valid_sel && out_free;
            if (xfer && last_sel) begin
               st_d = ST_IDLE;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= ST_IDLE;
         gnt_q    <= 1'b0;
         rr_ptr_q <= 1'b0;
         carry_q  <= 1'b0;
         sub_q    <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         st_q  <= st_d;
         gnt_q <= gnt_d;
         if (st_q == ST_IDLE && arb_any) begin
            first_q <= 1'b1;
         end
         if (xfer) begin
            first_q <= 1'b0;
            carry_q <= add_cout;
            sub_q   <= sub_eff;
            if (last_sel) begin
               rr_ptr_q <= ~gnt_q;
            end
         end
      end
   end

   // Output register: load wins over drain so both may occur together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_id    <= 1'b0;
         res_last  <= 1'b0;
         res_cout  <= 1'b0;
         res_ovf   <= 1'b0;
      end else if (xfer) begin
         res_valid <= 1'b1;
         res_sum   <= add_sum;
         res_id    <= gnt_q;
         res_last  <= last_sel;
         res_cout  <= last_sel & add_cout;
         res_ovf   <= last_sel &
                      signed_ovf(a_sel[WORD_W-1], b_eff[WORD_W-1],
                                 add_sum[WORD_W-1]);
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_id    <= 1'b0;
         res_last  <= 1'b0;
         res_cout  <= 1'b0;
         res_ovf   <= 1'b0;
      end
   end

endmodule
